// File: rtl/mux_arb_pkg.sv
// Shared constants and state encoding for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  // Requester 0 is searched first after reset.
  localparam logic [SEL_W-1:0] LAST_GRANT_RST = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin winner search: first asserted req bit at or after last+1, wrapping.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // NUM_REQ == 2**SEL_W, so the SEL_W-bit add wraps modulo NUM_REQ.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = last + SEL_W'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// 4-way round-robin arbiter feeding a one-entry registered output slot.
// Optional per-requester grant counters: define MUX_ARB_GRANT_CNT_EN.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
`ifdef MUX_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]  grant_cnt
`endif
);

  if (CNT_W == 0) begin : g_cnt_w_chk
    $error("mux_arbiter: CNT_W must be at least 1");
  end

  state_t             state;
  logic [SEL_W-1:0]   last_grant;
  logic               any;
  logic [SEL_W-1:0]   win;
  logic               load_en;
  logic               accept;
  logic [DATA_W-1:0]  words [NUM_REQ];

  rr_pick u_rr_pick (
    .req  (req_valid),
    .last (last_grant),
    .any  (any),
    .idx  (win)
  );

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      words[k] = req_data[k*DATA_W +: DATA_W];
    end
  end

  assign out_valid = (state == FULL);
  assign load_en   = !out_valid || out_ready;
  assign accept    = load_en && any;

  // Handshake is combinational, so it is gated by rst_n to stay quiet during reset.
  always_comb begin
    req_ready = '0;
    if (accept && rst_n) begin
      req_ready[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= LAST_GRANT_RST;
    end else if (accept) begin
      state      <= FULL;
      out_data   <= words[win];
      out_sel    <= win;
      last_grant <= win;
    end else if (out_ready) begin
      state      <= EMPTY;
    end
  end

`ifdef MUX_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        cnt[k] <= '0;
      end
    end else if (accept) begin
      cnt[win] <= cnt[win] + CNT_W'(1);
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      grant_cnt[k*CNT_W +: CNT_W] = cnt[k];
    end
  end
`endif

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter against a distance-based round-robin reference model.
module tb_mux_arbiter;

  localparam int DW = 8;
  localparam int CW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]     req_ready;
  logic           out_valid;
  logic [DW-1:0]  out_data;
  logic [1:0]     out_sel;
  logic           out_ready;
`ifdef MUX_ARB_GRANT_CNT_EN
  logic [4*CW-1:0] grant_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_sel;
  int            m_last;
  logic [CW-1:0] m_cnt [4];

  mux_arbiter #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef MUX_ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Winner = valid requester with the smallest cyclic distance past the last grant.
  function automatic int pick(input logic [3:0] v, input int last);
    int best = -1;
    int bestd = 99;
    for (int i = 0; i < 4; i++) begin
      if (v[i]) begin
        int d = (i - last - 1 + 8) % 4;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_data  = '0;
    m_sel   = 0;
    m_last  = 3;
    for (int i = 0; i < 4; i++) m_cnt[i] = '0;
  endtask

  task automatic step(input logic [3:0] v, input logic [4*DW-1:0] d, input logic rdy, input string tag);
    int w;
    bit acc;
    logic [3:0] exp_rdy;
    req_valid = v;
    req_data  = d;
    out_ready = rdy;
    exp_rdy   = 4'b0000;
    acc       = 0;
    w         = pick(v, m_last);
    if ((!m_valid || rdy) && v != 4'b0000) begin
      acc = 1;
      exp_rdy[w] = 1'b1;
    end
    #1;
    n_tests++;
    if (req_ready !== exp_rdy) begin
      n_fail++;
      $display("FAIL %s req_ready: got %b expected %b", tag, req_ready, exp_rdy);
    end
    @(posedge clk);
    if (acc) begin
      m_valid  = 1;
      m_data   = d[w*DW +: DW];
      m_sel    = w;
      m_last   = w;
      m_cnt[w] = m_cnt[w] + 1'b1;
    end else if (rdy) begin
      m_valid = 0;
    end
    #1;
    n_tests++;
    if (out_valid !== m_valid) begin
      n_fail++;
      $display("FAIL %s out_valid: got %b expected %b", tag, out_valid, m_valid);
    end
    if (m_valid) begin
      n_tests++;
      if (out_data !== m_data || out_sel !== 2'(m_sel)) begin
        n_fail++;
        $display("FAIL %s out_data/out_sel: got %h/%0d expected %h/%0d", tag, out_data, out_sel, m_data, m_sel);
      end
    end
  endtask

  task automatic do_reset();
    req_valid = 4'b0000;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag);
`ifdef MUX_ARB_GRANT_CNT_EN
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (grant_cnt[i*CW +: CW] !== m_cnt[i]) begin
        n_fail++;
        $display("FAIL %s grant_cnt[%0d]: got %0d expected %0d", tag, i, grant_cnt[i*CW +: CW], m_cnt[i]);
      end
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_data  = 32'hDEADBEEF;
    out_ready = 1'b1;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 2'd0 || req_ready !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_state: got v=%b d=%h s=%0d rdy=%b expected 0/00/0/0000",
                 out_valid, out_data, out_sel, req_ready);
      end
    end
    check_cnt("reset_cnt");
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_accept();
    step(4'b0001, 32'h000000A5, 1'b1, "first_accept");
    n_tests++;
    if (out_data !== 8'hA5 || out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL first_accept_const: got %h/%0d expected a5/0", out_data, out_sel);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] exp_d [4];
    exp_d[0] = 8'h10; exp_d[1] = 8'h21; exp_d[2] = 8'h32; exp_d[3] = 8'h43;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 32'h43322110, 1'b1, "rotation");
      n_tests++;
      if (out_sel !== 2'(i % 4) || out_data !== exp_d[i % 4]) begin
        n_fail++;
        $display("FAIL rotation_seq[%0d]: got %0d/%h expected %0d/%h", i, out_sel, out_data, i % 4, exp_d[i % 4]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step(4'b0001, 32'h00000055, 1'b1, "bp_load");
    for (int i = 0; i < 5; i++) begin
      step(4'b0110, 32'($urandom), 1'b0, "bp_hold");
      n_tests++;
      if (out_data !== 8'h55 || out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_data: got %h/%b expected 55/1", out_data, out_valid);
      end
    end
    step(4'b0110, 32'h00CCBB00, 1'b1, "bp_release");
    n_tests++;
    if (out_sel !== 2'd1 || out_data !== 8'hBB) begin
      n_fail++;
      $display("FAIL bp_release_sel: got %0d/%h expected 1/bb", out_sel, out_data);
    end
    step(4'b0000, 32'h0, 1'b1, "drain");
  endtask

  task automatic test_wrap();
    do_reset();
    step(4'b0100, 32'h00770000, 1'b1, "wrap_prime");
    step(4'b1001, 32'h880000AA, 1'b1, "wrap_first");
    n_tests++;
    if (out_sel !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_first_sel: got %0d expected 3", out_sel);
    end
    step(4'b1001, 32'h880000AA, 1'b1, "wrap_second");
    n_tests++;
    if (out_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_second_sel: got %0d expected 0", out_sel);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(4'b0001, 32'h0000003C, 1'b0, "arst_load");
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_fail++;
      $display("FAIL arst_immediate: got v=%b rdy=%b expected 0/0000", out_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(4'b1010, 32'h44003300, 1'b1, "arst_after");
    n_tests++;
    if (out_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL arst_after_sel: got %0d expected 1", out_sel);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(4'($urandom), 32'($urandom), ($urandom_range(0, 3) != 0), "random");
    end
    check_cnt("random_cnt");
  endtask

`ifdef MUX_ARB_GRANT_CNT_EN
  task automatic test_grant_cnt_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(4'b0100, 32'($urandom), 1'b1, "cnt_wrap");
    end
    n_tests++;
    if (grant_cnt !== 16'h0100) begin
      n_fail++;
      $display("FAIL cnt_wrap_value: got %h expected 0100", grant_cnt);
    end
    check_cnt("cnt_wrap_model");
  endtask
`endif

  initial begin
    test_reset();
    test_first_accept();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_random();
`ifdef MUX_ARB_GRANT_CNT_EN
    test_grant_cnt_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
